// File: rtl/fp_rsqrt_round_pack_if.sv
// Handshake/bus bundle between the inverse-sqrt mantissa pipeline, the
// round/pack stage and the downstream result consumer.
interface fp_rsqrt_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_mantissa;
  logic [7:0]  in_exponent;
  logic [2:0]  in_rounding_mode;
  logic        in_special_case;
  logic [31:0] in_special_result;
  logic        in_invalid;
  logic        in_div_by_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;
  logic        drop_err;

  modport master (
    output in_valid, in_mantissa, in_exponent, in_rounding_mode,
           in_special_case, in_special_result, in_invalid, in_div_by_zero,
           out_ready,
    input  in_ready, out_valid, out_result, out_flags, drop_err
  );

  modport slave (
    input  in_valid, in_mantissa, in_exponent, in_rounding_mode,
           in_special_case, in_special_result, in_invalid, in_div_by_zero,
           out_ready,
    output in_ready, out_valid, out_result, out_flags, drop_err
  );
endinterface

// File: rtl/fp_rsqrt_round_pack.sv
// Normalize/round/pack of a Q4.52 inverse-sqrt mantissa into binary32, with a
// credit-gated output FIFO. Optional sticky flag CSR image: FP_RSQRT_FLAG_ACCUM_EN.
module fp_rsqrt_round_pack #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_rsqrt_round_pack_if.slave  bus
`ifdef FP_RSQRT_FLAG_ACCUM_EN
  ,
  input  logic                  flags_clr,
  output logic [4:0]            flags_accum
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [22:0] frac;
    logic        g, r, s, sat;
    logic [7:0]  exp;
    logic [2:0]  rm;
    logic        spec;
    logic [31:0] spec_res;
    logic        inv, dbz;
  } sa_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
  } ent_t;

  // vld_pipe[0] = stage A, vld_pipe[1] = stage B
  logic [1:0]    vld_pipe;
  sa_t           a_d, a_q;
  ent_t          b_d, b_q;
  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] used;
  logic          accept, push, pop;
  logic          inc, carry, inexact;
  logic [22:0]   frac_r;
  logic [7:0]    exp_r;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = vld_pipe[1];
  assign pop    = bus.out_valid & bus.out_ready;

  // Stage A: pick the 23-bit fraction window depending on where the leading one sits
  always_comb begin
    a_d          = '0;
    a_d.rm       = bus.in_rounding_mode;
    a_d.spec     = bus.in_special_case;
    a_d.spec_res = bus.in_special_result;
    a_d.inv      = bus.in_invalid;
    a_d.dbz      = bus.in_div_by_zero;
    if (|bus.in_mantissa[55:53]) begin
      a_d.frac = '1;
      a_d.exp  = bus.in_exponent;
      a_d.sat  = 1'b1;
    end else if (bus.in_mantissa[52]) begin
      a_d.frac = bus.in_mantissa[51:29];
      a_d.g    = bus.in_mantissa[28];
      a_d.r    = bus.in_mantissa[27];
      a_d.s    = |bus.in_mantissa[26:0];
      a_d.exp  = bus.in_exponent;
    end else begin
      a_d.frac = bus.in_mantissa[50:28];
      a_d.g    = bus.in_mantissa[27];
      a_d.r    = bus.in_mantissa[26];
      a_d.s    = |bus.in_mantissa[25:0];
      a_d.exp  = bus.in_exponent - 8'd1;
    end
  end

  // Stage B: result is always positive, so RDN truncates like RTZ
  always_comb begin
    case (a_q.rm)
      3'b001, 3'b010: inc = 1'b0;
      3'b011:         inc = a_q.g | a_q.r | a_q.s;
      3'b100:         inc = a_q.g;
      default:        inc = a_q.g & (a_q.r | a_q.s | a_q.frac[0]);
    endcase
    {carry, frac_r} = {1'b0, a_q.frac} + 24'(inc);
    exp_r           = a_q.exp + 8'(carry);
    inexact         = a_q.g | a_q.r | a_q.s | a_q.sat;
    if (a_q.spec)
      b_d = '{result: a_q.spec_res, flags: {a_q.inv, a_q.dbz, 3'b000}};
    else
      b_d = '{result: {1'b0, exp_r, frac_r}, flags: {a_q.inv, a_q.dbz, 2'b00, inexact}};
  end

  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[0], accept};
  end

  always_ff @(posedge clk) begin
    if (accept)      a_q <= a_d;
    if (vld_pipe[0]) b_q <= b_d;
    if (push)        mem[wr_ptr] <= b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Credits cover every beat already in flight, so the FIFO can never overflow
  assign used         = (AW+2)'(count) + (AW+2)'(vld_pipe[0]) + (AW+2)'(vld_pipe[1]);
  assign bus.in_ready = used < (AW+2)'(FIFO_DEPTH);

  assign bus.out_valid  = count != '0;
  assign bus.out_result = bus.out_valid ? mem[rd_ptr].result : '0;
  assign bus.out_flags  = bus.out_valid ? mem[rd_ptr].flags  : '0;

  always_ff @(posedge clk) begin
    if (rst)                                bus.drop_err <= 1'b0;
    else if (bus.in_valid && !bus.in_ready) bus.drop_err <= 1'b1;
  end

`ifdef FP_RSQRT_FLAG_ACCUM_EN
  always_ff @(posedge clk) begin
    if (rst || flags_clr) flags_accum <= '0;
    else if (pop)         flags_accum <= flags_accum | bus.out_flags;
  end
`endif
endmodule
